// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one full-adder cell, LSB first.
// Latency: WIDTH cycles from the accepting edge to the result edge; done pulses for one cycle.
// Backpressure: start is ignored while busy; sum/cout hold the last result until the next completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter wide enough to reach WIDTH-1; kept at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_shift;

  // Single full-adder cell on the operand LSBs; the new sum bit enters at the MSB end
  // so that after WIDTH shifts the result register holds the sum in natural bit order.
  always_comb begin
    s_bit     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    c_next    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    res_shift = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_next;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last bit: publish the result including this cycle's sum bit and carry.
          sum_d   = res_shift;
          cout_d  = c_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder: adds two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder bit cell and a registered carry. It is the addition-side counterpart to the team's subtractor cells. It serves as the area-minimal mantissa/exponent adder in the multi-cycle floating-point datapath, where latency is traded for gate count. The block uses a start/done handshake and holds its result until the next operation completes.

## Interface
- WIDTH, 8, operand and sum width in bits (legal range 1..32)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset: asynchronous assert, active-low
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result a+b mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- Reset is asynchronous and active-low. One clock domain only.
- Reset values: busy=0, done=0, sum=0, cout=0. FSM=IDLE; internal shift registers, carry and bit counter are all 0.
- FSM states: IDLE and RUN.
- IDLE:
  - start=1 at an edge: latch a and b into operand shift registers, clear the internal carry, set counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, once per cycle:
  - bit cell computes s = a_sr[0] ^ b_sr[0] ^ c and c_next = majority(a_sr[0], b_sr[0], c).
  - s shifts into the MSB end of the internal result shift register (right shift).
  - Operand registers shift right by 1; carry register <= c_next; counter increments.
- RUN, on the cycle where counter = WIDTH-1:
  - Copy the completed result (including that cycle's s) to sum, and c_next to cout.
  - Pulse done; return to IDLE.
- sum and cout change only at completion. They hold the previous result throughout a new computation.
- start while busy=1 is ignored (no queuing). a and b may change freely after the accepting edge.
- Reset during RUN aborts the operation: outputs go to reset values, no done pulse, and the partial result is discarded.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry, so {cout,sum} = a+b exactly.

## Timing
- Accepting edge T0 (start=1, busy=0).
- busy=1 from after T0 through the cycle before edge T0+WIDTH.
- At edge T0+WIDTH: sum/cout updated, done=1 for exactly one cycle, busy=0.
- Latency is WIDTH cycles from accepting edge to result edge.
- busy=0 in the done cycle, so start=1 during done is accepted at edge T0+WIDTH+1. Maximum throughput is one operation per WIDTH+1 cycles.
- WIDTH=1: busy high for one cycle; done at T0+1.
- done and busy are never high in the same cycle.

## Test plan
- Reset, then idle: busy=0, done=0, sum=0, cout=0 held over 20 cycles with start=0.
- WIDTH=8, a=8'hFF, b=8'h01, start at T0 -> busy high 8 cycles; at T0+8: done=1, sum=8'h00, cout=1.
- a=8'h3C, b=8'h5A -> sum=8'h96, cout=0 at T0+8. sum holds 8'h00 from the prior test until that edge.
- Back-to-back: start asserted in the done cycle with a=8'h80, b=8'h80 -> accepted; sum=8'h00, cout=1 at 9 cycles after the previous T0+8. A start pulse mid-RUN with different operands has no effect.
- Reset mid-operation: deassert rst_n 4 cycles after T0 -> outputs zero immediately, no done pulse. A fresh start after release gives the correct result.
- Randomised 1000 operations at WIDTH=1, 8 and 32, checked against {cout,sum}=a+b, with latency exactly WIDTH and exactly one done pulse per accepted start.
